imuldiv_mul_arbiter: RTL and testbench

Two-port arbiter that shares one iterative 32x32→64 signed Booth multiplier (`imuldiv_IntMulBooth`) between two independent val/rdy requesters, e.g. two datapath sequencers inside the imuldiv unit. It accepts one request at a time, issues it to the multiplier, and captures the 64-bit product. It then returns the product on the response port of the requester that owns the transaction. Per-port grant counters are kept for performance inspection.

---
 rtl/imuldiv_mul_arbiter.sv | 150 +++++++++++++++
 tb/tb_imuldiv_mul_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_mul_arbiter.sv
// Two-port val/rdy arbiter sharing one iterative Booth multiplier, with per-port grant counters.
// Define IMULDIV_MULARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module imuldiv_mul_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [31:0]      req0_msg_a,
    input  logic [31:0]      req0_msg_b,
    input  logic             req0_val,
    output logic             req0_rdy,
    output logic [63:0]      resp0_msg_result,
    output logic             resp0_val,
    input  logic             resp0_rdy,

    input  logic [31:0]      req1_msg_a,
    input  logic [31:0]      req1_msg_b,
    input  logic             req1_val,
    output logic             req1_rdy,
    output logic [63:0]      resp1_msg_result,
    output logic             resp1_val,
    input  logic             resp1_rdy,

    output logic [31:0]      mul_req_msg_a,
    output logic [31:0]      mul_req_msg_b,
    output logic             mul_req_val,
    input  logic             mul_req_rdy,
    input  logic [63:0]      mul_resp_msg_result,
    input  logic             mul_resp_val,
    output logic             mul_resp_rdy,

    output logic             busy,
    output logic             owner,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] result;
    logic        winner;
    logic        accept;
    logic        resp_fire;

`ifdef IMULDIV_MULARB_RR_EN
    logic        rr_ptr;

    // The pointer names the port that wins when both ports request together.
    always_comb begin
        winner = 1'b0;
        if (req0_val && req1_val)
            winner = rr_ptr;
        else if (req1_val)
            winner = 1'b1;
    end
`else
    assign winner = req1_val & ~req0_val;
`endif

    assign req0_rdy  = (state == IDLE) && req0_val && !winner;
    assign req1_rdy  = (state == IDLE) && req1_val && winner;
    assign accept    = (state == IDLE) && (req0_val || req1_val);
    assign resp_fire = owner ? resp1_rdy : resp0_rdy;

    assign mul_req_msg_a    = op_a;
    assign mul_req_msg_b    = op_b;
    assign resp0_msg_result = result;
    assign resp1_msg_result = result;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            result       <= '0;
            owner        <= 1'b0;
            busy         <= 1'b0;
            mul_req_val  <= 1'b0;
            mul_resp_rdy <= 1'b0;
            resp0_val    <= 1'b0;
            resp1_val    <= 1'b0;
            gnt_cnt0     <= '0;
            gnt_cnt1     <= '0;
`ifdef IMULDIV_MULARB_RR_EN
            rr_ptr       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a        <= winner ? req1_msg_a : req0_msg_a;
                        op_b        <= winner ? req1_msg_b : req0_msg_b;
                        owner       <= winner;
                        busy        <= 1'b1;
                        mul_req_val <= 1'b1;
                        state       <= ISSUE;
                        if (!winner && gnt_cnt0 != CNT_MAX)
                            gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
                        if (winner && gnt_cnt1 != CNT_MAX)
                            gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
                    end
                end
                ISSUE: begin
                    if (mul_req_rdy) begin
                        mul_req_val  <= 1'b0;
                        mul_resp_rdy <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (mul_resp_val) begin
                        result       <= mul_resp_msg_result;
                        mul_resp_rdy <= 1'b0;
                        resp0_val    <= !owner;
                        resp1_val    <= owner;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    // Owner stays put after the handshake so it can be inspected while idle.
                    if (resp_fire) begin
                        resp0_val <= 1'b0;
                        resp1_val <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef IMULDIV_MULARB_RR_EN
                        rr_ptr    <= ~owner;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Directed bench for imuldiv_mul_arbiter with a small fixed-latency multiplier model behind it.
module tb_imuldiv_mul_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [63:0] resp0_msg_result, resp1_msg_result;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [31:0] mul_req_msg_a, mul_req_msg_b;
    logic        mul_req_val, mul_req_rdy;
    logic [63:0] mul_resp_msg_result;
    logic        mul_resp_val, mul_resp_rdy;
    logic        busy, owner;
    logic [1:0]  gnt_cnt0, gnt_cnt1;

    int total = 0;
    int bad   = 0;

    imuldiv_mul_arbiter #(.CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .mul_req_msg_a(mul_req_msg_a), .mul_req_msg_b(mul_req_msg_b),
        .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy),
        .mul_resp_msg_result(mul_resp_msg_result), .mul_resp_val(mul_resp_val),
        .mul_resp_rdy(mul_resp_rdy),
        .busy(busy), .owner(owner), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: accepts when idle, answers two cycles after acceptance.
    logic        m_busy;
    logic [1:0]  m_cnt;
    logic [63:0] m_res;
    logic        stall, spurious;

    assign mul_req_rdy         = !m_busy && !stall;
    assign mul_resp_val        = (m_busy && m_cnt == 2'd0) || spurious;
    assign mul_resp_msg_result = spurious ? 64'hDEAD_BEEF_DEAD_BEEF : m_res;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 2'd0;
            m_res  <= 64'd0;
        end else if (mul_req_val && mul_req_rdy) begin
            m_busy <= 1'b1;
            m_cnt  <= 2'd2;
            m_res  <= $signed(mul_req_msg_a) * $signed(mul_req_msg_b);
        end else if (m_busy && m_cnt != 2'd0) begin
            m_cnt <= m_cnt - 2'd1;
        end else if (m_busy && mul_resp_rdy) begin
            m_busy <= 1'b0;
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        req0_val = 0; req1_val = 0; resp0_rdy = 0; resp1_rdy = 0;
        req0_msg_a = 0; req0_msg_b = 0; req1_msg_a = 0; req1_msg_b = 0;
        stall = 0; spurious = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Presents a request and returns on the falling edge after it was accepted.
    task automatic send(input bit port, input logic [31:0] a, input logic [31:0] b, output bit ok);
        ok = 0;
        if (port == 0) begin req0_msg_a = a; req0_msg_b = b; req0_val = 1; end
        else           begin req1_msg_a = a; req1_msg_b = b; req1_val = 1; end
        for (int i = 0; i < 50; i++) begin
            #1;
            if ((port == 0 && req0_rdy) || (port == 1 && req1_rdy)) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (port == 0) req0_val = 0; else req1_val = 0;
    endtask

    task automatic wait_resp(output bit port, output logic [63:0] res, output int cycles, output bit ok);
        ok = 0; cycles = 0; port = 0; res = '0;
        for (int i = 0; i < 100; i++) begin
            if (resp0_val || resp1_val) begin
                ok   = 1;
                port = resp1_val;
                res  = resp1_val ? resp1_msg_result : resp0_msg_result;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0h want 0", busy); end
        total++; if (owner !== 1'b0) begin bad++; $display("[TB] FAIL reset_owner: got %0h want 0", owner); end
        total++; if ({req0_rdy, req1_rdy, resp0_val, resp1_val, mul_req_val, mul_resp_rdy} !== 6'b0) begin
            bad++; $display("[TB] FAIL reset_ctrl: got %b want 000000",
                            {req0_rdy, req1_rdy, resp0_val, resp1_val, mul_req_val, mul_resp_rdy});
        end
        total++; if ({gnt_cnt0, gnt_cnt1} !== 4'b0) begin
            bad++; $display("[TB] FAIL reset_cnt: got %0h/%0h want 0/0", gnt_cnt0, gnt_cnt1);
        end
        total++; if (resp0_msg_result !== 64'd0 || mul_req_msg_a !== 32'd0 || mul_req_msg_b !== 32'd0) begin
            bad++; $display("[TB] FAIL reset_data: got %0h %0h %0h want 0", resp0_msg_result, mul_req_msg_a, mul_req_msg_b);
        end
    endtask

    task automatic test_port0_only();
        bit ok, port; logic [63:0] res; int cyc;
        do_reset();
        resp0_rdy = 1; resp1_rdy = 1;
        send(0, 32'd3, 32'd4, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL p0_accept: got no grant want grant"); end
        wait_resp(port, res, cyc, ok);
        total++; if (!ok || port !== 1'b0 || resp1_val !== 1'b0) begin
            bad++; $display("[TB] FAIL p0_route: got ok=%0d port=%0d r1val=%0d want 1 0 0", ok, port, resp1_val);
        end
        total++; if (res !== 64'h0000_0000_0000_000C) begin bad++; $display("[TB] FAIL p0_result: got %0h want c", res); end
        total++; if (cyc !== 4) begin bad++; $display("[TB] FAIL p0_latency: got %0d want 4", cyc); end
        total++; if (gnt_cnt0 !== 2'd1 || gnt_cnt1 !== 2'd0) begin
            bad++; $display("[TB] FAIL p0_cnt: got %0d/%0d want 1/0", gnt_cnt0, gnt_cnt1);
        end
        @(negedge clk);
        total++; if (busy !== 1'b0 || resp0_val !== 1'b0) begin
            bad++; $display("[TB] FAIL p0_done: got busy=%0d val=%0d want 0 0", busy, resp0_val);
        end
    endtask

    task automatic test_contention();
        bit          ports[4];
        logic [63:0] results[4];
        bit          exp_port[4];
        logic [63:0] exp_res[4];
        int          n;
        do_reset();
        resp0_rdy = 1; resp1_rdy = 1;
`ifdef IMULDIV_MULARB_RR_EN
        exp_port = '{0, 1, 0, 1};
        exp_res  = '{64'd30, 64'hFFFF_FFFF_FFFF_FFF2, 64'd30, 64'hFFFF_FFFF_FFFF_FFF2};
`else
        exp_port = '{0, 0, 0, 0};
        exp_res  = '{64'd30, 64'd30, 64'd30, 64'd30};
`endif
        req0_msg_a = 32'd5; req0_msg_b = 32'd6; req1_msg_a = 32'hFFFF_FFFE; req1_msg_b = 32'd7;
        req0_val = 1; req1_val = 1;
        #1;
        total++; if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
            bad++; $display("[TB] FAIL both_grant: got rdy0=%0d rdy1=%0d want 1 0", req0_rdy, req1_rdy);
        end
        n = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            if (resp0_val || resp1_val) begin
                ports[n]   = resp1_val;
                results[n] = resp1_val ? resp1_msg_result : resp0_msg_result;
                n++;
                if (n == 4) begin req0_val = 0; req1_val = 0; end
            end
            @(negedge clk);
        end
        total++; if (n !== 4) begin bad++; $display("[TB] FAIL both_count: got %0d want 4", n); end
        for (int i = 0; i < n; i++) begin
            total++; if (ports[i] !== exp_port[i] || results[i] !== exp_res[i]) begin
                bad++; $display("[TB] FAIL both_seq%0d: got port %0d res %0h want port %0d res %0h",
                                i, ports[i], results[i], exp_port[i], exp_res[i]);
            end
        end
`ifdef IMULDIV_MULARB_RR_EN
        total++; if (gnt_cnt0 !== 2'd2 || gnt_cnt1 !== 2'd2) begin
            bad++; $display("[TB] FAIL both_cnt: got %0d/%0d want 2/2", gnt_cnt0, gnt_cnt1);
        end
`else
        total++; if (gnt_cnt0 !== 2'd3 || gnt_cnt1 !== 2'd0) begin
            bad++; $display("[TB] FAIL both_cnt: got %0d/%0d want 3/0", gnt_cnt0, gnt_cnt1);
        end
`endif
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL both_idle: got busy=%0d want 0", busy); end
    endtask

    task automatic test_resp_hold();
        bit ok, port; logic [63:0] res; int cyc;
        do_reset();
        resp0_rdy = 0; resp1_rdy = 1;
        send(0, 32'd100000, 32'd300000, ok);
        req0_val = 1; req1_val = 1; req1_msg_a = 32'd1; req1_msg_b = 32'd1;
        wait_resp(port, res, cyc, ok);
        total++; if (!ok || port !== 1'b0 || res !== 64'h0000_0006_FC23_AC00) begin
            bad++; $display("[TB] FAIL hold_result: got ok=%0d port=%0d res=%0h want 1 0 6fc23ac00", ok, port, res);
        end
        for (int i = 0; i < 10; i++) begin
            total++; if (resp0_val !== 1'b1 || resp0_msg_result !== 64'h0000_0006_FC23_AC00 || resp1_val !== 1'b0) begin
                bad++; $display("[TB] FAIL hold_resp%0d: got val=%0d res=%0h v1=%0d want 1 6fc23ac00 0",
                                i, resp0_val, resp0_msg_result, resp1_val);
            end
            total++; if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("[TB] FAIL hold_ctrl%0d: got rdy0=%0d rdy1=%0d busy=%0d want 0 0 1",
                                i, req0_rdy, req1_rdy, busy);
            end
            @(negedge clk);
        end
        req0_val = 0; req1_val = 0; resp0_rdy = 1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || resp0_val !== 1'b0 || gnt_cnt1 !== 2'd0) begin
            bad++; $display("[TB] FAIL hold_release: got busy=%0d val=%0d cnt1=%0d want 0 0 0", busy, resp0_val, gnt_cnt1);
        end
    endtask

    task automatic test_issue_stall();
        bit ok, port; logic [63:0] res; int cyc;
        do_reset();
        resp0_rdy = 1; resp1_rdy = 1;
        stall = 1; spurious = 1;
        send(0, 32'd7, 32'hFFFF_FFFD, ok);
        for (int i = 0; i < 5; i++) begin
            total++; if (mul_req_val !== 1'b1 || mul_req_msg_a !== 32'd7 || mul_req_msg_b !== 32'hFFFF_FFFD || mul_resp_rdy !== 1'b0) begin
                bad++; $display("[TB] FAIL stall%0d: got val=%0d a=%0h b=%0h rrdy=%0d want 1 7 fffffffd 0",
                                i, mul_req_val, mul_req_msg_a, mul_req_msg_b, mul_resp_rdy);
            end
            @(negedge clk);
        end
        stall = 0; spurious = 0;
        wait_resp(port, res, cyc, ok);
        total++; if (!ok || (cyc + 5) !== 9) begin bad++; $display("[TB] FAIL stall_latency: got %0d want 9", cyc + 5); end
        total++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            bad++; $display("[TB] FAIL stall_result: got %0h want ffffffffffffffeb", res);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        bit ok, port, found; logic [63:0] res; int cyc;
        do_reset();
        resp0_rdy = 1; resp1_rdy = 1;
        send(1, 32'd9, 32'd9, ok);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (mul_resp_rdy) begin found = 1; break; end
            @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("[TB] FAIL mid_wait: got no WAIT want WAIT"); end
        reset = 0;
        @(negedge clk);
        total++; if ({busy, owner, mul_req_val, mul_resp_rdy, resp0_val, resp1_val} !== 6'b0 || gnt_cnt1 !== 2'd0) begin
            bad++; $display("[TB] FAIL mid_reset: got %b cnt1=%0d want 000000 0",
                            {busy, owner, mul_req_val, mul_resp_rdy, resp0_val, resp1_val}, gnt_cnt1);
        end
        reset = 1;
        send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ok);
        wait_resp(port, res, cyc, ok);
        total++; if (!ok || port !== 1'b0 || res !== 64'd1) begin
            bad++; $display("[TB] FAIL mid_after: got ok=%0d port=%0d res=%0h want 1 0 1", ok, port, res);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        bit ok, port; logic [63:0] res; int cyc;
        logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        resp0_rdy = 1; resp1_rdy = 1;
        for (int i = 0; i < 5; i++) begin
            send(0, 32'(i), 32'd2, ok);
            wait_resp(port, res, cyc, ok);
            @(negedge clk);
            total++; if (!ok || gnt_cnt0 !== exp_cnt[i]) begin
                bad++; $display("[TB] FAIL sat%0d: got ok=%0d cnt0=%0d want 1 %0d", i, ok, gnt_cnt0, exp_cnt[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_port0_only();
        test_contention();
        test_resp_hold();
        test_issue_stall();
        test_reset_midflight();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
